// File: rtl/trap_sequencer_if.sv
// Pipeline-side handshake between the commit stage and the trap sequencer:
// exception/xRET reports and drain acknowledge in, flush and redirect out.
interface trap_sequencer_if;
   logic        exc_valid;
   logic [8:0]  exc_vec;
   logic        ret;
   logic [31:0] exc_epc;
   logic [31:0] exc_badaddr;
   logic        pipe_drained;
   logic        pipe_clear;
   logic        insert_pc;
   logic [31:0] priv_pc;

   modport master (
      output exc_valid, exc_vec, ret, exc_epc, exc_badaddr, pipe_drained,
      input  pipe_clear, insert_pc, priv_pc
   );

   modport slave (
      input  exc_valid, exc_vec, ret, exc_epc, exc_badaddr, pipe_drained,
      output pipe_clear, insert_pc, priv_pc
   );
endinterface

// File: rtl/trap_sequencer.sv
// Trap/xRET sequencer: latches the winning event, flushes the pipeline, then
// issues a single-cycle redirect with the matching CSR update strobe.
module trap_sequencer #(
   parameter int unsigned DRAIN_TIMEOUT = 16,
   parameter bit          VECTOR_EN     = 1'b1
) (
   input  logic                   CLK,
   input  logic                   nRST,
   trap_sequencer_if.slave        pipe,
   input  logic [2:0]             int_pending,
   input  logic                   int_enable,
   input  logic [31:0]            xtvec,
   input  logic [31:0]            xepc,
   output logic [31:0]            trap_cause,
   output logic [31:0]            trap_epc,
   output logic [31:0]            trap_val,
   output logic                   trap_commit,
   output logic                   ret_commit,
   output logic                   busy,
   output logic                   drain_timeout
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      REDIRECT
   } state_t;

   localparam logic [4:0] DRAIN_LAST = 5'(DRAIN_TIMEOUT - 1);

   state_t      state;
   logic [4:0]  drain_cnt;
   logic        pend_int;
   logic        pend_ret;

   logic        exc_hit;
   logic        int_hit;
   logic        trig;
   logic [2:0]  int_masked;
   logic [4:0]  exc_code;
   logic [4:0]  int_code;
   logic [31:0] vec_base;
   logic        vec_on;
   logic [31:0] target;

   always_comb begin
      exc_hit    = pipe.exc_valid && (pipe.exc_vec != '0);
      int_masked = int_pending & {3{int_enable}};
      int_hit    = |int_masked;
      trig       = exc_hit || int_hit || pipe.ret;

      // Priority order happens to follow the bit order of exc_vec, MSB first.
      exc_code = 5'd0;
      priority casez (pipe.exc_vec)
         9'b1????????: exc_code = 5'd1;
         9'b01???????: exc_code = 5'd0;
         9'b001??????: exc_code = 5'd2;
         9'b0001?????: exc_code = 5'd3;
         9'b00001????: exc_code = 5'd11;
         9'b000001???: exc_code = 5'd4;
         9'b0000001??: exc_code = 5'd6;
         9'b00000001?: exc_code = 5'd5;
         9'b000000001: exc_code = 5'd7;
         default:      exc_code = 5'd0;
      endcase

      if (int_masked[2])      int_code = 5'd11;
      else if (int_masked[1]) int_code = 5'd3;
      else                    int_code = 5'd7;

      vec_base = {xtvec[31:2], 2'b00};
      vec_on   = VECTOR_EN && (xtvec[1:0] == 2'b01);

      if (pend_ret)
         target = xepc;
      else if (pend_int && vec_on)
         target = vec_base + {25'd0, trap_cause[4:0], 2'b00};
      else
         target = vec_base;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state           <= IDLE;
         drain_cnt       <= '0;
         pend_int        <= 1'b0;
         pend_ret        <= 1'b0;
         trap_cause      <= '0;
         trap_epc        <= '0;
         trap_val        <= '0;
         trap_commit     <= 1'b0;
         ret_commit      <= 1'b0;
         busy            <= 1'b0;
         drain_timeout   <= 1'b0;
         pipe.pipe_clear <= 1'b0;
         pipe.insert_pc  <= 1'b0;
         pipe.priv_pc    <= '0;
      end else begin
         pipe.insert_pc <= 1'b0;
         trap_commit    <= 1'b0;
         ret_commit     <= 1'b0;

         unique case (state)
            IDLE: begin
               if (trig) begin
                  state           <= DRAIN;
                  drain_cnt       <= '0;
                  busy            <= 1'b1;
                  pipe.pipe_clear <= 1'b1;
                  trap_epc        <= pipe.exc_epc;
                  if (exc_hit) begin
                     trap_cause <= {1'b0, 26'd0, exc_code};
                     trap_val   <= pipe.exc_badaddr;
                     pend_int   <= 1'b0;
                     pend_ret   <= 1'b0;
                  end else if (int_hit) begin
                     trap_cause <= {1'b1, 26'd0, int_code};
                     trap_val   <= '0;
                     pend_int   <= 1'b1;
                     pend_ret   <= 1'b0;
                  end else begin
                     pend_int   <= 1'b0;
                     pend_ret   <= 1'b1;
                  end
               end
            end

            DRAIN: begin
               // A drain acknowledge on the final counted cycle is not a timeout.
               if (pipe.pipe_drained || (drain_cnt == DRAIN_LAST)) begin
                  if (!pipe.pipe_drained)
                     drain_timeout <= 1'b1;
                  state          <= REDIRECT;
                  pipe.insert_pc <= 1'b1;
                  pipe.priv_pc   <= target;
                  trap_commit    <= !pend_ret;
                  ret_commit     <= pend_ret;
               end else begin
                  drain_cnt <= drain_cnt + 5'd1;
               end
            end

            REDIRECT: begin
               state           <= IDLE;
               busy            <= 1'b0;
               pipe.pipe_clear <= 1'b0;
            end

            default: begin
               state           <= IDLE;
               busy            <= 1'b0;
               pipe.pipe_clear <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an event-level model.
module tb_trap_sequencer;
   localparam int unsigned TMO = 16;

   logic        CLK  = 1'b0;
   logic        nRST = 1'b0;
   logic [2:0]  int_pending;
   logic        int_enable;
   logic [31:0] xtvec;
   logic [31:0] xepc;
   logic [31:0] trap_cause;
   logic [31:0] trap_epc;
   logic [31:0] trap_val;
   logic        trap_commit;
   logic        ret_commit;
   logic        busy;
   logic        drain_timeout;

   trap_sequencer_if pipe();

   trap_sequencer #(.DRAIN_TIMEOUT(TMO), .VECTOR_EN(1'b1)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .pipe          (pipe),
      .int_pending   (int_pending),
      .int_enable    (int_enable),
      .xtvec         (xtvec),
      .xepc          (xepc),
      .trap_cause    (trap_cause),
      .trap_epc      (trap_epc),
      .trap_val      (trap_val),
      .trap_commit   (trap_commit),
      .ret_commit    (ret_commit),
      .busy          (busy),
      .drain_timeout (drain_timeout)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Event-level model: what is in flight, how long it has waited, what it redirects to.
   int exc_code_of_bit[9] = '{7, 5, 6, 4, 11, 3, 2, 0, 1};
   int int_code_of_bit[3] = '{7, 3, 11};

   bit          m_inflight = 0;
   bit          m_redir    = 0;
   int          m_waited   = 0;
   int          m_kind     = 0;   // 0 exception, 1 interrupt, 2 xRET
   logic [31:0] m_cause    = '0;
   logic [31:0] m_epc      = '0;
   logic [31:0] m_val      = '0;
   logic [31:0] m_ppc      = '0;
   bit          m_tmo      = 0;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_inflight = 0; m_redir = 0; m_waited = 0; m_kind = 0;
         m_cause = '0; m_epc = '0; m_val = '0; m_ppc = '0; m_tmo = 0;
      end else if (m_redir) begin
         m_redir    = 0;
         m_inflight = 0;
      end else if (m_inflight) begin
         m_waited++;
         if (pipe.pipe_drained || m_waited == TMO) begin
            logic [31:0] base;
            if (!pipe.pipe_drained) m_tmo = 1;
            base = xtvec & 32'hFFFF_FFFC;
            if (m_kind == 2)
               m_ppc = xepc;
            else if (m_kind == 1 && xtvec[1:0] == 2'b01)
               m_ppc = base + (m_cause & 32'h7FFF_FFFF) * 4;
            else
               m_ppc = base;
            m_redir = 1;
         end
      end else begin
         logic [2:0] im;
         bit found;
         im = int_pending & {3{int_enable}};
         found = 0;
         if (pipe.exc_valid && pipe.exc_vec != 0) begin
            for (int i = 8; i >= 0; i--)
               if (!found && pipe.exc_vec[i]) begin
                  found = 1;
                  m_cause = 32'(exc_code_of_bit[i]);
               end
            m_val = pipe.exc_badaddr; m_kind = 0;
         end else if (im != 0) begin
            for (int i = 2; i >= 0; i--)
               if (!found && im[i]) begin
                  found = 1;
                  m_cause = 32'h8000_0000 | 32'(int_code_of_bit[i]);
               end
            m_val = '0; m_kind = 1;
         end else if (pipe.ret) begin
            m_kind = 2;
         end
         if (pipe.exc_valid && pipe.exc_vec != 0 || im != 0 || pipe.ret) begin
            m_epc = pipe.exc_epc; m_inflight = 1; m_waited = 0;
         end
      end
   end

   always @(negedge CLK) begin
      chkb("busy", busy, m_inflight);
      chkb("pipe_clear", pipe.pipe_clear, m_inflight);
      chkb("insert_pc", pipe.insert_pc, m_redir);
      chkb("trap_commit", trap_commit, m_redir && m_kind != 2);
      chkb("ret_commit", ret_commit, m_redir && m_kind == 2);
      chkb("drain_timeout", drain_timeout, m_tmo);
      chk("trap_cause", trap_cause, m_cause);
      chk("trap_epc", trap_epc, m_epc);
      chk("trap_val", trap_val, m_val);
      chk("priv_pc", pipe.priv_pc, m_ppc);
   end

   task automatic idle_inputs();
      pipe.exc_valid = 0; pipe.exc_vec = '0; pipe.ret = 0;
      pipe.exc_epc = '0; pipe.exc_badaddr = '0; pipe.pipe_drained = 0;
      int_pending = '0; int_enable = 0;
   endtask

   task automatic raise_exc(input logic [8:0] v, input logic [31:0] epc, input logic [31:0] bad);
      pipe.exc_valid = 1; pipe.exc_vec = v; pipe.exc_epc = epc; pipe.exc_badaddr = bad;
      @(negedge CLK);
      pipe.exc_valid = 0; pipe.exc_vec = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int dp[4] = '{0, 5, 30, 90};
      int dprob;
      bit seen;

      idle_inputs();
      xtvec = '0; xepc = '0;
      repeat (2) @(negedge CLK);
      chk("rst_cause", trap_cause, 32'h0);
      chk("rst_priv_pc", pipe.priv_pc, 32'h0);
      chkb("rst_busy", busy, 1'b0);
      nRST = 1;
      @(negedge CLK);

      // illegal_insn + mal_l, drained immediately
      xtvec = 32'h8000_0001;
      raise_exc(9'b001001000, 32'h100, 32'hBAD0_0010);
      chkb("t1_clear", pipe.pipe_clear, 1'b1);
      chkb("t1_noins", pipe.insert_pc, 1'b0);
      chk("t1_cause", trap_cause, 32'd2);
      chk("t1_epc", trap_epc, 32'h100);
      pipe.pipe_drained = 1;
      @(negedge CLK);
      pipe.pipe_drained = 0;
      chkb("t1_ins", pipe.insert_pc, 1'b1);
      chkb("t1_tc", trap_commit, 1'b1);
      chk("t1_ppc", pipe.priv_pc, 32'h8000_0000);
      @(negedge CLK);
      chkb("t1_ins_off", pipe.insert_pc, 1'b0);
      chkb("t1_idle", busy, 1'b0);

      // timer + ext, vectored
      int_enable = 1; int_pending = 3'b101; pipe.exc_badaddr = 32'h1234_5678;
      @(negedge CLK);
      int_pending = '0; int_enable = 0; pipe.pipe_drained = 1;
      chk("t2_cause", trap_cause, 32'h8000_000B);
      chk("t2_val", trap_val, 32'h0);
      @(negedge CLK);
      pipe.pipe_drained = 0;
      chkb("t2_ins", pipe.insert_pc, 1'b1);
      chk("t2_ppc", pipe.priv_pc, 32'h8000_002C);
      @(negedge CLK);

      // xRET alongside an empty exception report
      xepc = 32'h2040; pipe.ret = 1; pipe.exc_valid = 1; pipe.exc_vec = '0; pipe.exc_epc = 32'h3000;
      @(negedge CLK);
      pipe.ret = 0; pipe.exc_valid = 0; pipe.pipe_drained = 1;
      chk("t3_cause_kept", trap_cause, 32'h8000_000B);
      chk("t3_epc", trap_epc, 32'h3000);
      @(negedge CLK);
      pipe.pipe_drained = 0;
      chkb("t3_rc", ret_commit, 1'b1);
      chkb("t3_tc", trap_commit, 1'b0);
      chk("t3_ppc", pipe.priv_pc, 32'h2040);
      @(negedge CLK);

      // drain never acknowledged: forced redirect after 16 DRAIN cycles
      raise_exc(9'b000100000, 32'h400, 32'h44);
      for (int i = 0; i < 16; i++) begin
         chkb("t4_draining", pipe.pipe_clear && !pipe.insert_pc, 1'b1);
         @(negedge CLK);
      end
      chkb("t4_ins", pipe.insert_pc, 1'b1);
      chkb("t4_tmo", drain_timeout, 1'b1);
      chk("t4_ppc", pipe.priv_pc, 32'h8000_0000);
      repeat (5) @(negedge CLK);
      chkb("t4_tmo_sticky", drain_timeout, 1'b1);

      // ext interrupt arrives during DRAIN, taken in the first IDLE cycle
      raise_exc(9'b000100000, 32'h500, 32'h55);
      int_enable = 1; int_pending = 3'b100;
      repeat (3) @(negedge CLK);
      pipe.pipe_drained = 1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (pipe.insert_pc) seen = 1; else @(negedge CLK);
      end
      chkb("t5_redirect_seen", seen, 1'b1);
      pipe.pipe_drained = 0;
      chk("t5_first_cause", trap_cause, 32'd3);
      @(negedge CLK);
      chkb("t5_idle_gap", busy, 1'b0);
      @(negedge CLK);
      chkb("t5_taken", busy, 1'b1);
      chk("t5_cause", trap_cause, 32'h8000_000B);
      int_pending = '0; int_enable = 0; pipe.pipe_drained = 1;
      @(negedge CLK);
      pipe.pipe_drained = 0;
      @(negedge CLK);

      // reset pulsed mid-DRAIN
      raise_exc(9'b000000010, 32'h600, 32'h66);
      #2 nRST = 0;
      #1;
      chk("t6_all_zero", {trap_cause | trap_epc | trap_val | pipe.priv_pc}, 32'h0);
      chkb("t6_flags_zero", busy | pipe.pipe_clear | drain_timeout | pipe.insert_pc, 1'b0);
      @(negedge CLK);
      nRST = 1;
      seen = 0;
      repeat (20) begin
         @(negedge CLK);
         if (pipe.insert_pc || trap_commit) seen = 1;
      end
      chkb("t6_no_redirect", seen, 1'b0);

      // randomized traffic
      dprob = 30;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) dprob = dp[$urandom_range(0, 3)];
         pipe.exc_valid    = ($urandom_range(0, 9) == 0);
         pipe.exc_vec      = ($urandom_range(0, 3) == 0) ? 9'b0 : (9'($urandom) & 9'($urandom));
         pipe.ret          = ($urandom_range(0, 9) == 0);
         int_pending       = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b0;
         int_enable        = 1'($urandom_range(0, 1));
         pipe.pipe_drained = ($urandom_range(0, 99) < dprob);
         xtvec             = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFE1 : $urandom;
         xepc              = $urandom;
         pipe.exc_epc      = $urandom;
         pipe.exc_badaddr  = $urandom;
         if ($urandom_range(0, 599) == 0) begin
            #2 nRST = 0;
            @(negedge CLK);
            nRST = 1;
         end else begin
            @(negedge CLK);
         end
      end

      idle_inputs();
      repeat (20) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
